// File: rtl/lcd_rx.sv
// lcd_rx: samples a parallel RGB565 display bus, recovers pixel coordinates and frame markers,
// and measures frame geometry. Define LCD_RX_MEASURE_EN to build the HS/VS period counters.
module lcd_rx #(
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic        lcd_en,
    input  logic [15:0] lcd_rgb,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [10:0] pix_xpos,
    output logic [10:0] pix_ypos,
    output logic        frame_start,
    output logic        frame_done,
    output logic [10:0] h_active,
    output logic [10:0] v_active,
    output logic [11:0] h_total,
    output logic [10:0] v_total,
    output logic        locked,
    output logic        line_err
);
    localparam logic [0:0]  ST_WAIT_VS = 1'b0;
    localparam logic [0:0]  ST_FRAME   = 1'b1;
    localparam logic [10:0] MAX11      = 11'd2047;

    // Input stage (syncs stored already normalised to active-high)
    logic        vs1_q, vs2_q, de1_q, de2_q;
    logic [15:0] rgb1_q;
    logic        de_rise, de_fall, vs_lead;

    logic [0:0]  state_q, state_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [10:0] ref_len_q, ref_len_d, last_len_q, last_len_d;
    logic        have_ref_q, have_ref_d;

    logic        pix_valid_q, pix_valid_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic [10:0] pix_xpos_q, pix_xpos_d, pix_ypos_q, pix_ypos_d;
    logic        frame_start_q, frame_start_d, frame_done_q, frame_done_d;
    logic [10:0] h_active_q, h_active_d, v_active_q, v_active_d;
    logic        locked_q, locked_d, line_err_q, line_err_d;

    logic [10:0] x_inc, y_inc, line_len, x_cur, end_len, end_y;

    assign de_rise  = de1_q & ~de2_q;
    assign de_fall  = ~de1_q & de2_q;
    assign vs_lead  = vs1_q & ~vs2_q;
    assign x_inc    = (x_q == MAX11) ? MAX11 : x_q + 11'd1;
    assign y_inc    = (y_q == MAX11) ? MAX11 : y_q + 11'd1;
    // Length of a saturated line is clamped so it still fits the 11-bit field
    assign line_len = x_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs1_q  <= 1'b0;
            vs2_q  <= 1'b0;
            de1_q  <= 1'b0;
            de2_q  <= 1'b0;
            rgb1_q <= '0;
        end else begin
            vs1_q  <= (lcd_vs == VS_POL);
            vs2_q  <= vs1_q;
            de1_q  <= lcd_en;
            de2_q  <= de1_q;
            rgb1_q <= lcd_rgb;
        end
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        ref_len_d     = ref_len_q;
        have_ref_d    = have_ref_q;
        last_len_d    = last_len_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_xpos_d    = pix_xpos_q;
        pix_ypos_d    = pix_ypos_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        h_active_d    = h_active_q;
        v_active_d    = v_active_q;
        locked_d      = locked_q;
        line_err_d    = line_err_q;
        x_cur         = de_rise ? 11'd0 : x_inc;
        end_len       = last_len_q;
        end_y         = y_q;

        if (state_q == ST_WAIT_VS) begin
            if (vs_lead) begin
                state_d       = ST_FRAME;
                frame_start_d = 1'b1;
                x_d           = '0;
                y_d           = '0;
                have_ref_d    = 1'b0;
                last_len_d    = '0;
                line_err_d    = 1'b0;
            end
        end else begin
            if (de1_q) begin
                pix_valid_d = 1'b1;
                pix_data_d  = rgb1_q;
                pix_xpos_d  = x_cur;
                pix_ypos_d  = y_q;
                x_d         = x_cur;
                if (x_cur == MAX11) line_err_d = 1'b1;
            end
            // A line ending on the VS edge is accounted before the frame latch below
            if (de_fall) begin
                y_d        = y_inc;
                last_len_d = line_len;
                end_len    = line_len;
                end_y      = y_inc;
                if (!have_ref_q) begin
                    ref_len_d  = line_len;
                    have_ref_d = 1'b1;
                end else if (line_len != ref_len_q) begin
                    line_err_d = 1'b1;
                end
            end
            if (vs_lead) begin
                frame_start_d = 1'b1;
                frame_done_d  = 1'b1;
                h_active_d    = end_len;
                v_active_d    = end_y;
                locked_d      = (end_len == h_active_q) && (end_y == v_active_q) &&
                                (end_len != 11'd0) && (end_y != 11'd0);
                x_d           = '0;
                y_d           = '0;
                have_ref_d    = 1'b0;
                last_len_d    = '0;
                line_err_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_WAIT_VS;
            x_q           <= '0;
            y_q           <= '0;
            ref_len_q     <= '0;
            have_ref_q    <= 1'b0;
            last_len_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_xpos_q    <= '0;
            pix_ypos_q    <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            h_active_q    <= '0;
            v_active_q    <= '0;
            locked_q      <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            ref_len_q     <= ref_len_d;
            have_ref_q    <= have_ref_d;
            last_len_q    <= last_len_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_xpos_q    <= pix_xpos_d;
            pix_ypos_q    <= pix_ypos_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            h_active_q    <= h_active_d;
            v_active_q    <= v_active_d;
            locked_q      <= locked_d;
            line_err_q    <= line_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_xpos    = pix_xpos_q;
    assign pix_ypos    = pix_ypos_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign h_active    = h_active_q;
    assign v_active    = v_active_q;
    assign locked      = locked_q;
    assign line_err    = line_err_q;

`ifdef LCD_RX_MEASURE_EN
    localparam logic [11:0] MAX12 = 12'd4095;

    logic        hs1_q, hs2_q, hs_lead;
    logic        h_seen_q, h_seen_d;
    logic [11:0] h_cnt_q, h_cnt_d, h_total_q, h_total_d;
    logic [10:0] v_cnt_q, v_cnt_d, v_total_q, v_total_d;

    assign hs_lead = hs1_q & ~hs2_q;

    // h_total is only latched once a full HS period has been seen inside a frame
    always_comb begin
        h_cnt_d   = h_cnt_q;
        h_seen_d  = h_seen_q;
        v_cnt_d   = v_cnt_q;
        h_total_d = h_total_q;
        v_total_d = v_total_q;
        if (state_q == ST_WAIT_VS) begin
            if (vs_lead) begin
                h_cnt_d  = '0;
                h_seen_d = hs_lead;
                v_cnt_d  = {10'd0, hs_lead};
            end
        end else begin
            h_cnt_d = (h_cnt_q == MAX12) ? MAX12 : h_cnt_q + 12'd1;
            if (hs_lead) begin
                if (h_seen_q) h_total_d = (h_cnt_q == MAX12) ? MAX12 : h_cnt_q + 12'd1;
                h_cnt_d  = '0;
                h_seen_d = 1'b1;
                v_cnt_d  = (v_cnt_q == MAX11) ? MAX11 : v_cnt_q + 11'd1;
            end
            if (vs_lead) begin
                v_total_d = v_cnt_q;
                v_cnt_d   = {10'd0, hs_lead};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs1_q     <= 1'b0;
            hs2_q     <= 1'b0;
            h_seen_q  <= 1'b0;
            h_cnt_q   <= '0;
            h_total_q <= '0;
            v_cnt_q   <= '0;
            v_total_q <= '0;
        end else begin
            hs1_q     <= (lcd_hs == HS_POL);
            hs2_q     <= hs1_q;
            h_seen_q  <= h_seen_d;
            h_cnt_q   <= h_cnt_d;
            h_total_q <= h_total_d;
            v_cnt_q   <= v_cnt_d;
            v_total_q <= v_total_d;
        end
    end

    assign h_total = h_total_q;
    assign v_total = v_total_q;
`else
    assign h_total = '0;
    assign v_total = '0;
`endif

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx on a scaled-down raster (16 clocks x 10 lines, 8x6 active, active-low syncs).
module tb_lcd_rx;
    localparam int HT = 16, VT = 10, HSW = 2, VSW = 2, HBP = 4, HA = 8, VBP = 3;
`ifdef LCD_RX_MEASURE_EN
    localparam logic [22:0] EXP_TOT = {12'd16, 11'd10};
`else
    localparam logic [22:0] EXP_TOT = 23'd0;
`endif

    logic        clk, rst, lcd_hs, lcd_vs, lcd_en;
    logic [15:0] lcd_rgb, pix_data;
    logic        pix_valid, frame_start, frame_done, locked, line_err;
    logic [10:0] pix_xpos, pix_ypos, h_active, v_active, v_total;
    logic [11:0] h_total;

    lcd_rx dut (
        .clk(clk), .rst(rst), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_en(lcd_en), .lcd_rgb(lcd_rgb),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_xpos(pix_xpos), .pix_ypos(pix_ypos),
        .frame_start(frame_start), .frame_done(frame_done), .h_active(h_active), .v_active(v_active),
        .h_total(h_total), .v_total(v_total), .locked(locked), .line_err(line_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        fs;
        logic        fd;
        logic [10:0] x;
        logic [10:0] y;
        logic [15:0] d;
    } exp_t;

    exp_t        q0, q1, first_exp;
    logic [40:0] first_got;
    logic        armed, prev_vs, err_prev;
    logic [25:0] snap;
    logic [22:0] snap_tot;
    logic [11:0] pre_snap;
    logic [87:0] rst_snap;
    int          tests, fails, bad;
    time         first_t;

    // One input word per clock; outputs seen at this negedge belong to the word driven two ticks ago
    task automatic tick(input logic hs_a, input logic vs_a, input logic en, input logic [15:0] rgb,
                        input logic [10:0] ex, input logic [10:0] ey);
        @(negedge clk);
        if (pix_valid !== q1.v || frame_start !== q1.fs || frame_done !== q1.fd ||
            (q1.v && (pix_xpos !== q1.x || pix_ypos !== q1.y || pix_data !== q1.d))) begin
            if (bad == 0) begin
                first_t   = $time;
                first_exp = q1;
                first_got = {pix_valid, frame_start, frame_done, pix_xpos, pix_ypos, pix_data};
            end
            bad++;
        end
        q1      = q0;
        q0.fs   = vs_a & ~prev_vs;
        q0.fd   = vs_a & ~prev_vs & armed;
        q0.v    = armed & en;
        q0.x    = ex;
        q0.y    = ey;
        q0.d    = rgb;
        if (q0.fs) armed = 1'b1;
        prev_vs = vs_a;
        lcd_hs  = ~hs_a;
        lcd_vs  = ~vs_a;
        lcd_en  = en;
        lcd_rgb = rgb;
    endtask

    task automatic drive_frame(input int va, input int short_y, input bit tail, input int rst_y);
        for (int r = 0; r < VT; r++) begin
            for (int c = 0; c < HT; c++) begin
                int   x, y, hl;
                logic en;
                hl = (r - VBP == short_y) ? HA - 1 : HA;
                en = (r >= VBP) && (r < VBP + va) && (c >= HBP) && (c < HBP + hl);
                x  = c - HBP;
                y  = r - VBP;
                if (tail && r == VT - 1 && c >= HT - HA) begin
                    en = 1'b1;
                    x  = c - (HT - HA);
                    y  = va;
                end
                tick(c < HSW, r < VSW, en, {r[7:0], c[7:0]}, x[10:0], y[10:0]);
                if (r == 0 && c == 1) err_prev = line_err;
                if (r == 0 && c == 2) begin
                    snap     = {frame_start, frame_done, locked, line_err, h_active, v_active};
                    snap_tot = {h_total, v_total};
                end
                if (r == rst_y && c == HBP + 3) begin
                    pre_snap = {pix_valid, h_active};
                    #2 rst = 1'b1;
                    #1 rst_snap = {pix_valid, pix_data, pix_xpos, pix_ypos, frame_start, frame_done,
                                   h_active, v_active, h_total, v_total, locked, line_err};
                    armed   = 1'b0;
                    prev_vs = 1'b0;
                    q0      = '0;
                    q1      = '0;
                    @(negedge clk);
                    rst = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; lcd_hs = 1'b1; lcd_vs = 1'b1; lcd_en = 1'b0; lcd_rgb = '0;
        q0 = '0; q1 = '0; armed = 1'b0; prev_vs = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({pix_valid, pix_data, pix_xpos, pix_ypos, frame_start, frame_done, h_active, v_active,
             h_total, v_total, locked, line_err} !== 88'd0) begin
            fails++; $display("FAIL reset_outputs: valid=%b xpos=%0d h_active=%0d locked=%b, want all 0",
                              pix_valid, pix_xpos, h_active, locked);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            int c;
            c = i % 16;
            tick(c < HSW, 1'b0, (c >= HBP) && (c < HBP + HA), 16'hA500 | i[15:0], 11'd0, 11'd0);
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL idle_no_pixels: %0d bad cycles, first at %0t got %h want %h",
                              bad, first_t, first_got, first_exp);
        end
        tests++;
        if ({h_active, v_active, locked, line_err} !== 24'd0) begin
            fails++; $display("FAIL idle_geometry: h=%0d v=%0d lock=%b err=%b, want 0",
                              h_active, v_active, locked, line_err);
        end
    endtask

    task automatic test_nominal();
        bad = 0;
        drive_frame(6, -100, 1'b0, -100);
        tests++;
        if (snap !== {1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0}) begin
            fails++; $display("FAIL first_vs_no_latch: got %h want %h", snap, {4'b1000, 22'd0});
        end
        drive_frame(6, -100, 1'b0, -100);
        tests++;
        if (snap !== {1'b1, 1'b1, 1'b0, 1'b0, 11'd8, 11'd6}) begin
            fails++; $display("FAIL second_vs_latch: got %h want %h", snap, {4'b1100, 11'd8, 11'd6});
        end
        tests++;
        if (snap_tot !== EXP_TOT) begin
            fails++; $display("FAIL totals: got %h want %h", snap_tot, EXP_TOT);
        end
        drive_frame(6, -100, 1'b0, -100);
        tests++;
        if (snap !== {1'b1, 1'b1, 1'b1, 1'b0, 11'd8, 11'd6}) begin
            fails++; $display("FAIL third_vs_locked: got %h want %h", snap, {4'b1110, 11'd8, 11'd6});
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL nominal_pixels: %0d bad cycles, first at %0t got %h want %h",
                              bad, first_t, first_got, first_exp);
        end
    endtask

    task automatic test_line_err();
        bad = 0;
        drive_frame(6, 2, 1'b0, -100);
        tests++;
        if ({err_prev, snap} !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'd8, 11'd6}) begin
            fails++; $display("FAIL pre_short_frame: got %h want %h", {err_prev, snap}, {5'b01110, 11'd8, 11'd6});
        end
        drive_frame(5, -100, 1'b0, -100);
        tests++;
        if (err_prev !== 1'b1) begin
            fails++; $display("FAIL line_err_set: got %b want 1", err_prev);
        end
        tests++;
        if (snap !== {1'b1, 1'b1, 1'b1, 1'b0, 11'd8, 11'd6}) begin
            fails++; $display("FAIL line_err_cleared: got %h want %h", snap, {4'b1110, 11'd8, 11'd6});
        end
        drive_frame(5, -100, 1'b0, -100);
        tests++;
        if (snap !== {1'b1, 1'b1, 1'b0, 1'b0, 11'd8, 11'd5}) begin
            fails++; $display("FAIL geometry_change_unlock: got %h want %h", snap, {4'b1100, 11'd8, 11'd5});
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL line_err_pixels: %0d bad cycles, first at %0t got %h want %h",
                              bad, first_t, first_got, first_exp);
        end
    endtask

    task automatic test_simultaneous();
        bad = 0;
        drive_frame(5, -100, 1'b1, -100);
        tests++;
        if (snap !== {1'b1, 1'b1, 1'b1, 1'b0, 11'd8, 11'd5}) begin
            fails++; $display("FAIL relock_5_lines: got %h want %h", snap, {4'b1110, 11'd8, 11'd5});
        end
        drive_frame(5, -100, 1'b0, -100);
        tests++;
        if ({err_prev, snap} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd8, 11'd6}) begin
            fails++; $display("FAIL de_fall_on_vs: got %h want %h", {err_prev, snap}, {5'b01100, 11'd8, 11'd6});
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL simul_pixels: %0d bad cycles, first at %0t got %h want %h",
                              bad, first_t, first_got, first_exp);
        end
    endtask

    task automatic test_mid_reset();
        bad = 0;
        drive_frame(6, -100, 1'b0, 5);
        tests++;
        if (pre_snap !== {1'b1, 11'd8}) begin
            fails++; $display("FAIL pre_reset_active: got %h want %h", pre_snap, {1'b1, 11'd8});
        end
        tests++;
        if (rst_snap !== 88'd0) begin
            fails++; $display("FAIL async_reset_clear: got %h want 0", rst_snap);
        end
        drive_frame(6, -100, 1'b0, -100);
        tests++;
        if (snap !== {1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0}) begin
            fails++; $display("FAIL post_reset_first_vs: got %h want %h", snap, {4'b1000, 22'd0});
        end
        drive_frame(6, -100, 1'b0, -100);
        tests++;
        if (snap !== {1'b1, 1'b1, 1'b0, 1'b0, 11'd8, 11'd6}) begin
            fails++; $display("FAIL post_reset_latch: got %h want %h", snap, {4'b1100, 11'd8, 11'd6});
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL mid_reset_pixels: %0d bad cycles, first at %0t got %h want %h",
                              bad, first_t, first_got, first_exp);
        end
    endtask

    task automatic test_saturation();
        bad = 0;
        for (int i = 0; i < 4; i++) tick(i == 0, 1'b1, 1'b0, 16'd0, 11'd0, 11'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 16'd0, 11'd0, 11'd0);
        for (int i = 0; i < 2052; i++) begin
            logic [10:0] ex;
            ex = (i > 2047) ? 11'd2047 : i[10:0];
            tick(1'b0, 1'b0, 1'b1, i[15:0], ex, 11'd0);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 16'd0, 11'd0, 11'd0);
        tests++;
        if (line_err !== 1'b1) begin
            fails++; $display("FAIL x_sat_line_err: got %b want 1", line_err);
        end
        for (int i = 0; i < 4; i++) tick(i == 0, 1'b1, 1'b0, 16'd0, 11'd0, 11'd0);
        tests++;
        if ({h_active, v_active, line_err} !== {11'd2047, 11'd1, 1'b0}) begin
            fails++; $display("FAIL x_sat_latch: h=%0d v=%0d err=%b want 2047 1 0", h_active, v_active, line_err);
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL x_sat_pixels: %0d bad cycles, first at %0t got %h want %h",
                              bad, first_t, first_got, first_exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        bad   = 0;
        test_reset();
        test_nominal();
        test_line_err();
        test_simultaneous();
        test_mid_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
